// File: rtl/instr_sequencer.sv
// Program sequencer: holds a 16-word program buffer and issues one instruction
// per accepted cycle to the datapath, with stall, single-step and abort control.
module instr_sequencer #(
  parameter int IW    = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_instr,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic          step_mode,
  input  logic          step,
  input  logic          stall,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          load_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          vld_q, vld_d;
  logic          lerr_q, lerr_d;
  logic          wr_en;
  logic          last;

  logic [IW-1:0] mem [DEPTH];

  // len_q is never zero while in RUN, so len_q-1 cannot underflow there.
  assign last = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    vld_d   = 1'b0;
    lerr_d  = lerr_q;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_en) begin
          wr_en = 1'b1;
          if (state_q == S_DONE) state_d = S_IDLE;
        end else if (start && !abort) begin
          len_d   = prog_len;
          pc_d    = '0;
          lerr_d  = 1'b0;
          state_d = (prog_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (load_en) lerr_d = 1'b1;
        if (!abort && !stall && (!step_mode || step)) begin
          instr_d = mem[pc_q];
          vld_d   = 1'b1;
          if (last) begin
            pc_d    = '0;
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything but leaves the last issued word on instr_out.
    if (abort) begin
      state_d = S_IDLE;
      pc_d    = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      lerr_q  <= lerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[load_addr] <= load_instr;
  end

  assign instr_out   = instr_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign load_err    = lerr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table covering load/run/stall/step/
// abort/load_err, plus hand sequences for a 16-word run and an async mid-run reset.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [3:0] load_addr;
  logic [8:0] load_instr;
  logic [4:0] prog_len;
  logic       start, abort, step_mode, step, stall;
  logic [8:0] instr_out;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy, done, load_err;

  instr_sequencer #(.IW(9), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .prog_len(prog_len), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .stall(stall), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       ld;
    logic [3:0] la;
    logic [8:0] li;
    logic [4:0] pl;
    logic       st, ab, sm, sp, sl;
    logic [8:0] e_io;
    logic       e_v;
    logic [3:0] e_pc;
    logic       e_busy, e_done, e_lerr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [8:0] WA = 9'b111_0101_00;
  localparam logic [8:0] WB = 9'b111_0011_01;
  localparam logic [8:0] WC = 9'b000_00_01_10;

  function automatic void add(string nm, logic ld, logic [3:0] la, logic [8:0] li,
                              logic [4:0] pl, logic st, logic ab, logic sm, logic sp,
                              logic sl, logic [8:0] e_io, logic e_v, logic [3:0] e_pc,
                              logic e_busy, logic e_done, logic e_lerr);
    vec_t v;
    v.nm = nm; v.ld = ld; v.la = la; v.li = li; v.pl = pl;
    v.st = st; v.ab = ab; v.sm = sm; v.sp = sp; v.sl = sl;
    v.e_io = e_io; v.e_v = e_v; v.e_pc = e_pc;
    v.e_busy = e_busy; v.e_done = e_done; v.e_lerr = e_lerr;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [8:0] e_io, logic e_v, logic [3:0] e_pc,
                     logic e_busy, logic e_done, logic e_lerr);
    logic [16:0] act, exp;
    act = {instr_out, instr_valid, pc, busy, done, load_err};
    exp = {e_io, e_v, e_pc, e_busy, e_done, e_lerr};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got io=%h v=%b pc=%0d busy=%b done=%b lerr=%b, want io=%h v=%b pc=%0d busy=%b done=%b lerr=%b",
               nm, instr_out, instr_valid, pc, busy, done, load_err,
               e_io, e_v, e_pc, e_busy, e_done, e_lerr);
    end
  endtask

  task automatic idle_inputs();
    load_en = 0; load_addr = 0; load_instr = 0; prog_len = 0;
    start = 0; abort = 0; step_mode = 0; step = 0; stall = 0;
  endtask

  function automatic logic [8:0] word16(int i);
    return 9'((i * 37 + 5) % 512);
  endfunction

  initial begin
    //   name         ld la  li     pl  st ab sm sp sl   io  v pc  b  d  le
    add("load0",      1, 0, WA,     0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    add("load1",      1, 1, WB,     0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    add("load2",      1, 2, WC,     0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    add("t1_start",   0, 0, 0,      3,  1, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0);
    add("t1_iss0",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WA, 1, 1, 1, 0, 0);
    add("t1_iss1",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 1, 2, 1, 0, 0);
    add("t1_iss2",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WC, 1, 0, 0, 1, 0);
    add("t1_hold",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WC, 0, 0, 0, 1, 0);
    add("t2_start",   0, 0, 0,      3,  1, 0, 0, 0, 0,  WC, 0, 0, 1, 0, 0);
    add("t2_iss0",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WA, 1, 1, 1, 0, 0);
    add("t2_stall0",  0, 0, 0,      0,  0, 0, 0, 0, 1,  WA, 0, 1, 1, 0, 0);
    add("t2_stall1",  0, 0, 0,      0,  0, 0, 0, 0, 1,  WA, 0, 1, 1, 0, 0);
    add("t2_iss1",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 1, 2, 1, 0, 0);
    add("t2_stlast",  0, 0, 0,      0,  0, 0, 0, 0, 1,  WB, 0, 2, 1, 0, 0);
    add("t2_iss2",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WC, 1, 0, 0, 1, 0);
    add("t2_hold",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WC, 0, 0, 0, 1, 0);
    add("t3_start",   0, 0, 0,      2,  1, 0, 1, 0, 0,  WC, 0, 0, 1, 0, 0);
    add("t3_wait0",   0, 0, 0,      0,  0, 0, 1, 0, 0,  WC, 0, 0, 1, 0, 0);
    add("t3_step0",   0, 0, 0,      0,  0, 0, 1, 1, 0,  WA, 1, 1, 1, 0, 0);
    add("t3_wait1",   0, 0, 0,      0,  0, 0, 1, 0, 0,  WA, 0, 1, 1, 0, 0);
    add("t3_stepstl", 0, 0, 0,      0,  0, 0, 1, 1, 1,  WA, 0, 1, 1, 0, 0);
    add("t3_step1",   0, 0, 0,      0,  0, 0, 1, 1, 0,  WB, 1, 0, 0, 1, 0);
    add("t3_hold",    0, 0, 0,      0,  0, 0, 1, 0, 0,  WB, 0, 0, 0, 1, 0);
    add("t4_ldDone",  1, 3, 9'h0AA, 0,  0, 0, 0, 0, 0,  WB, 0, 0, 0, 0, 0);
    add("t4_len0",    0, 0, 0,      0,  1, 0, 0, 0, 0,  WB, 0, 0, 0, 1, 0);
    add("t4_len0h",   0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 0, 0, 0, 1, 0);
    add("t5_start",   0, 0, 0,      3,  1, 0, 0, 0, 0,  WB, 0, 0, 1, 0, 0);
    add("t5_ldRun",   1, 1, 9'h155, 0,  0, 0, 0, 0, 0,  WA, 1, 1, 1, 0, 1);
    add("t5_iss1",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 1, 2, 1, 0, 1);
    add("t5_iss2",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WC, 1, 0, 0, 1, 1);
    add("t5_restart", 0, 0, 0,      3,  1, 0, 0, 0, 0,  WC, 0, 0, 1, 0, 0);
    add("t5_iss0",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WA, 1, 1, 1, 0, 0);
    add("t5_bufkept", 0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 1, 2, 1, 0, 0);
    add("t5_abort",   0, 0, 0,      0,  0, 1, 0, 0, 0,  WB, 0, 0, 0, 0, 0);
    add("t5_idle",    0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 0, 0, 0, 0, 0);
    add("ld_vs_st",   1, 0, WA,     3,  1, 0, 0, 0, 0,  WB, 0, 0, 0, 0, 0);
    add("ld_vs_st_h", 0, 0, 0,      0,  0, 0, 0, 0, 0,  WB, 0, 0, 0, 0, 0);
    add("st_abort",   0, 0, 0,      3,  1, 1, 0, 0, 0,  WB, 0, 0, 0, 0, 0);
    add("t6_start",   0, 0, 0,      3,  1, 0, 0, 0, 0,  WB, 0, 0, 1, 0, 0);
    add("st_in_run",  0, 0, 0,      1,  1, 0, 0, 0, 1,  WB, 0, 0, 1, 0, 0);
    add("abort_stl",  0, 0, 0,      0,  0, 1, 0, 0, 1,  WB, 0, 0, 0, 0, 0);

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven section: drive at negedge, check just after the next posedge.
    for (int i = 0; i < vecs.size(); i++) begin
      load_en = vecs[i].ld; load_addr = vecs[i].la; load_instr = vecs[i].li;
      prog_len = vecs[i].pl; start = vecs[i].st; abort = vecs[i].ab;
      step_mode = vecs[i].sm; step = vecs[i].sp; stall = vecs[i].sl;
      @(posedge clk); #1;
      chk(vecs[i].nm, vecs[i].e_io, vecs[i].e_v, vecs[i].e_pc,
          vecs[i].e_busy, vecs[i].e_done, vecs[i].e_lerr);
      @(negedge clk);
    end
    idle_inputs();

    // Full 16-entry program: pc wraps to 0 on the last issue.
    for (int i = 0; i < 16; i++) begin
      load_en = 1; load_addr = 4'(i); load_instr = word16(i);
      @(negedge clk);
    end
    idle_inputs();
    prog_len = 5'd16; start = 1;
    @(posedge clk); #1;
    chk("t4_len16_start", WB, 0, 0, 1, 0, 0);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t4_len16_iss%0d", i), word16(i), 1, 4'((i + 1) % 16),
          (i != 15), (i == 15), 0);
    end
    @(negedge clk);

    // Asynchronous reset between clock edges in the middle of a run.
    prog_len = 5'd16; start = 1;
    @(negedge clk);
    start = 0;
    @(posedge clk); @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_rst_held", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    prog_len = 5'd2; start = 1;
    @(posedge clk); #1;
    chk("t6_restart", 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    chk("t6_iss0", word16(0), 1, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk("t6_iss1", word16(1), 1, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
